// File: rtl/uart_word_tx_if.sv
// Write-side handshake for uart_word_tx: a 64-bit word with its strobe, plus
// the back-pressure signal returned to the producer.
interface uart_word_tx_if;
    logic [63:0] uart_data;
    logic        uart_en;
    logic        uart_tx_ready;

    modport master (output uart_data, output uart_en, input uart_tx_ready);
    modport slave  (input uart_data, input uart_en, output uart_tx_ready);
endinterface

// File: rtl/uart_word_tx.sv
// Buffers 64-bit words in a small FIFO and sends each one MSB byte first as 8N1.
// Define UART_FRAME_HDR_EN to wrap each word as A5 + 8 data bytes + XOR checksum.
module uart_word_tx #(
    parameter int unsigned BAUD_DIV = 434,
    parameter int unsigned FIFO_AW  = 2
) (
    input  logic          uart_clk,
    input  logic          reset_n,
    uart_word_tx_if.slave wr,
    output logic          uart_txd,
    output logic          busy,
    output logic          overflow
);
    localparam int unsigned          DEPTH       = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]     FULL_CNT    = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]     CNT_ONE     = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0]   PTR_ONE     = FIFO_AW'(1);
    localparam logic [15:0]          BAUD_RELOAD = 16'(BAUD_DIV - 1);
`ifdef UART_FRAME_HDR_EN
    localparam logic [3:0]           LAST_BYTE   = 4'd9;
`else
    localparam logic [3:0]           LAST_BYTE   = 4'd7;
`endif

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_DATA, S_STOP} state_t;

    logic [63:0]        r_mem [DEPTH];
    logic [63:0]        r_rd_data;
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               r_overflow;

    state_t             r_state, w_state_next;
    logic [15:0]        r_baud, w_baud_next;
    logic [2:0]         r_bit, w_bit_next;
    logic [3:0]         r_byte, w_byte_next;
    logic [7:0]         r_shift, w_shift_next;
    logic [63:0]        r_word, w_word_next;
    logic               r_txd, w_txd_next;

    logic               w_ready;
    logic               w_push;
    logic               w_pop;
    logic               w_bit_end;
    logic [7:0]         w_word_bytes [8];
    logic [7:0]         w_first_byte;
    logic [7:0]         w_next_byte;

    assign w_ready   = (r_count != FULL_CNT);
    assign w_push    = wr.uart_en && w_ready;
    assign w_bit_end = (r_baud == 16'd0);

    assign wr.uart_tx_ready = w_ready;
    assign uart_txd         = r_txd;
    assign busy             = (r_state != S_IDLE) || (r_count != '0);
    assign overflow         = r_overflow;

    for (genvar gi = 0; gi < 8; gi++) begin : g_word_bytes
        assign w_word_bytes[gi] = r_word[63-8*gi -: 8];
    end

`ifdef UART_FRAME_HDR_EN
    logic [7:0] w_csum [9];
    assign w_csum[0] = 8'h00;
    for (genvar gi = 0; gi < 8; gi++) begin : g_csum
        assign w_csum[gi+1] = w_csum[gi] ^ w_word_bytes[gi];
    end
    // Byte index n (1..8) carries data byte n-1, which equals the current index.
    assign w_first_byte = 8'hA5;
    assign w_next_byte  = (r_byte == 4'd8) ? w_csum[8] : w_word_bytes[r_byte[2:0]];
`else
    assign w_first_byte = r_rd_data[63:56];
    assign w_next_byte  = w_word_bytes[r_byte[2:0] + 3'd1];
`endif

    // Word storage has no reset so it maps onto block RAM; the head word is
    // read every cycle and is already valid during LOAD.
    always_ff @(posedge uart_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr.uart_data;
        end
        r_rd_data <= r_mem[r_rd_ptr];
    end

    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud;
        w_bit_next   = r_bit;
        w_byte_next  = r_byte;
        w_shift_next = r_shift;
        w_word_next  = r_word;
        w_pop        = 1'b0;
        w_txd_next   = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) w_state_next = S_LOAD;
            end
            S_LOAD: begin
                w_pop        = 1'b1;
                w_word_next  = r_rd_data;
                w_byte_next  = 4'd0;
                w_shift_next = w_first_byte;
                w_baud_next  = BAUD_RELOAD;
                w_state_next = S_START;
            end
            S_START: begin
                if (w_bit_end) begin
                    w_baud_next  = BAUD_RELOAD;
                    w_bit_next   = 3'd0;
                    w_state_next = S_DATA;
                end else begin
                    w_baud_next = r_baud - 16'd1;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_baud_next  = BAUD_RELOAD;
                    w_shift_next = {1'b0, r_shift[7:1]};
                    if (r_bit == 3'd7) w_state_next = S_STOP;
                    else               w_bit_next   = r_bit + 3'd1;
                end else begin
                    w_baud_next = r_baud - 16'd1;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    if (r_byte != LAST_BYTE) begin
                        w_byte_next  = r_byte + 4'd1;
                        w_shift_next = w_next_byte;
                        w_baud_next  = BAUD_RELOAD;
                        w_state_next = S_START;
                    end else if (r_count != '0) begin
                        w_state_next = S_LOAD;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end else begin
                    w_baud_next = r_baud - 16'd1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        // Line level is registered from the next state so uart_txd is glitch-free.
        case (w_state_next)
            S_START: w_txd_next = 1'b0;
            S_DATA:  w_txd_next = w_shift_next[0];
            default: w_txd_next = 1'b1;
        endcase
    end

    always_ff @(posedge uart_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_baud     <= 16'd0;
            r_bit      <= 3'd0;
            r_byte     <= 4'd0;
            r_shift    <= 8'd0;
            r_word     <= 64'd0;
            r_txd      <= 1'b1;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_baud  <= w_baud_next;
            r_bit   <= w_bit_next;
            r_byte  <= w_byte_next;
            r_shift <= w_shift_next;
            r_word  <= w_word_next;
            r_txd   <= w_txd_next;
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (wr.uart_en && !w_ready) r_overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_word_tx.sv
// Scoreboard bench for uart_word_tx: expected bytes are queued on each accepted
// write and checked by a serial decoder watching uart_txd.
`timescale 1ns/1ps
module tb_uart_word_tx;
    localparam int BAUD = 4;
`ifdef UART_FRAME_HDR_EN
    localparam int BPW = 10;
`else
    localparam int BPW = 8;
`endif
    localparam int WORD_CYC = BPW * 10 * BAUD;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic txd, busy, overflow;

    uart_word_tx_if wr_if();

    uart_word_tx #(.BAUD_DIV(BAUD), .FIFO_AW(2)) dut (
        .uart_clk (clk),
        .reset_n  (reset_n),
        .wr       (wr_if),
        .uart_txd (txd),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rst_cnt = 0;
    logic [7:0] sb [$];
    int t_starts [$];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge reset_n) rst_cnt <= rst_cnt + 1;

    // Serial decoder: samples each bit mid-cell; bytes straddling a reset are dropped.
    initial begin : monitor
        int rc;
        int t0;
        logic [7:0] b;
        logic [7:0] exp_b;
        logic good;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && txd === 1'b0) begin
                rc = rst_cnt; t0 = cyc; good = 1'b1;
                repeat (BAUD / 2) @(negedge clk);
                if (txd !== 1'b0) good = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    repeat (BAUD) @(negedge clk);
                    b[i] = txd;
                end
                repeat (BAUD) @(negedge clk);
                if (txd !== 1'b1) good = 1'b0;
                if (rc == rst_cnt) begin
                    t_starts.push_back(t0);
                    n_tests++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL serial_byte: got %02h, required no byte (nothing queued)", b);
                    end else begin
                        exp_b = sb.pop_front();
                        if (!good || b !== exp_b) begin
                            n_fail++;
                            $display("FAIL serial_byte: got %02h framing_ok=%0b, required %02h framing_ok=1", b, good, exp_b);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    function automatic void push_expected(input logic [63:0] w);
        logic [7:0] cs = 8'h00;
`ifdef UART_FRAME_HDR_EN
        sb.push_back(8'hA5);
`endif
        for (int i = 0; i < 8; i++) begin
            sb.push_back(w[63-8*i -: 8]);
            cs ^= w[63-8*i -: 8];
        end
`ifdef UART_FRAME_HDR_EN
        sb.push_back(cs);
`endif
    endfunction

    task automatic write_word(input logic [63:0] w, input logic exp_acc);
        @(negedge clk);
        wr_if.uart_en   = 1'b1;
        wr_if.uart_data = w;
        if (exp_acc) push_expected(w);
        @(posedge clk);
    endtask

    task automatic end_write();
        @(negedge clk);
        wr_if.uart_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        sb.delete();
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_drain(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int ph = 0; ph < 2; ph++) begin
            n_tests++;
            if ({txd, wr_if.uart_tx_ready, busy, overflow} !== 4'b1100) begin
                n_fail++;
                $display("FAIL reset_state ph%0d: got txd/ready/busy/ovf=%b%b%b%b, required 1100",
                         ph, txd, wr_if.uart_tx_ready, busy, overflow);
            end
            reset_n = 1'b1;
            repeat (20) @(negedge clk);
        end
    endtask

    task automatic test_single_word();
        logic ok;
        logic exp;
        t_starts.delete();
        write_word(64'h0123456789ABCDEF, 1'b1);
        end_write();
        for (int k = 1; k <= WORD_CYC + 4; k++) begin
            @(negedge clk);
            if (k <= 5) begin
                exp = (k >= 2) ? 1'b0 : 1'b1;
                n_tests++;
                if (txd !== exp) begin
                    n_fail++;
                    $display("FAIL start_latency k=%0d: got txd=%b, required %b", k, txd, exp);
                end
            end
            if (k == WORD_CYC + 1 || k == WORD_CYC + 2) begin
                exp = (k == WORD_CYC + 1);
                n_tests++;
                if (busy !== exp) begin
                    n_fail++;
                    $display("FAIL busy_fall k=%0d: got busy=%b, required %b", k, busy, exp);
                end
            end
        end
        wait_drain(ok);
        n_tests++;
        if (!ok || sb.size() != 0 || t_starts.size() != BPW) begin
            n_fail++;
            $display("FAIL single_drain: got idle=%b left=%0d bytes=%0d, required idle=1 left=0 bytes=%0d",
                     ok, sb.size(), t_starts.size(), BPW);
        end
    endtask

    task automatic test_fill_overflow();
        logic ok;
        int d;
        int exp_d;
        t_starts.delete();
        for (int i = 0; i < 5; i++) write_word(64'hA000_0000_0000_0000 + 64'(i * 64'h0101_0101_0101_0111), 1'b1);
        @(negedge clk);
        n_tests++;
        if (wr_if.uart_tx_ready !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_ready: got ready=%b ovf=%b, required ready=0 ovf=0", wr_if.uart_tx_ready, overflow);
        end
        wr_if.uart_data = 64'hDEAD_BEEF_DEAD_BEEF;
        @(posedge clk);
        end_write();
        n_tests++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_overflow: got ovf=%b, required 1", overflow);
        end
        wait_drain(ok);
        n_tests++;
        if (!ok || sb.size() != 0 || t_starts.size() != 5 * BPW) begin
            n_fail++;
            $display("FAIL fill_drain: got idle=%b left=%0d bytes=%0d, required idle=1 left=0 bytes=%0d",
                     ok, sb.size(), t_starts.size(), 5 * BPW);
        end
        for (int i = 1; i < t_starts.size(); i++) begin
            d = t_starts[i] - t_starts[i-1];
            exp_d = 10 * BAUD + ((i % BPW == 0) ? 1 : 0);
            n_tests++;
            if (d != exp_d) begin
                n_fail++;
                $display("FAIL byte_spacing i=%0d: got %0d cycles, required %0d", i, d, exp_d);
            end
        end
    endtask

    task automatic test_push_pop_full();
        logic ok;
        do_reset();
        for (int i = 0; i < 5; i++) write_word(64'h5500_0000_0000_0000 | 64'(i + 1), 1'b1);
        end_write();
        repeat (WORD_CYC - 2) @(negedge clk);
        // This is the LOAD cycle of word 2: FIFO full, pop pending.
        n_tests++;
        if (wr_if.uart_tx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL load_ready: got ready=%b, required 0", wr_if.uart_tx_ready);
        end
        wr_if.uart_en   = 1'b1;
        wr_if.uart_data = 64'hBAD0_BAD0_BAD0_BAD0;
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (overflow !== 1'b1 || wr_if.uart_tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL pushpop_full: got ovf=%b ready=%b, required ovf=1 ready=1", overflow, wr_if.uart_tx_ready);
        end
        wr_if.uart_data = 64'hC0DE_C0DE_1234_5678;
        push_expected(64'hC0DE_C0DE_1234_5678);
        @(posedge clk);
        end_write();
        n_tests++;
        if (wr_if.uart_tx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL refill_ready: got ready=%b, required 0", wr_if.uart_tx_ready);
        end
        wait_drain(ok);
        n_tests++;
        if (!ok || sb.size() != 0) begin
            n_fail++;
            $display("FAIL pushpop_drain: got idle=%b left=%0d, required idle=1 left=0", ok, sb.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        logic ok;
        do_reset();
        write_word(64'h1122_0000_4455_6677, 1'b1);
        end_write();
        repeat (130) @(negedge clk);
        n_tests++;
        if (txd !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_frame_low: got txd=%b, required 0", txd);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_tests++;
        if ({txd, busy, wr_if.uart_tx_ready} !== 3'b101) begin
            n_fail++;
            $display("FAIL async_reset: got txd/busy/ready=%b%b%b, required 101", txd, busy, wr_if.uart_tx_ready);
        end
        sb.delete();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (60) @(negedge clk);
        write_word(64'hFEDC_BA98_7654_3210, 1'b1);
        end_write();
        wait_drain(ok);
        n_tests++;
        if (!ok || sb.size() != 0) begin
            n_fail++;
            $display("FAIL post_reset_word: got idle=%b left=%0d, required idle=1 left=0", ok, sb.size());
        end
    endtask

    task automatic test_frame_hdr();
        logic ok;
        t_starts.delete();
        write_word(64'h0102_0408_1020_4080, 1'b1);
        end_write();
        wait_drain(ok);
        n_tests++;
        if (!ok || sb.size() != 0 || t_starts.size() != BPW) begin
            n_fail++;
            $display("FAIL frame_bytes: got idle=%b left=%0d bytes=%0d, required idle=1 left=0 bytes=%0d",
                     ok, sb.size(), t_starts.size(), BPW);
        end
    endtask

    initial begin
        wr_if.uart_en   = 1'b0;
        wr_if.uart_data = '0;
        test_reset();
        test_single_word();
        test_fill_overflow();
        test_push_pop_full();
        test_reset_mid_frame();
        test_frame_hdr();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
